// File: rtl/mem_bus_responder.sv
// Memory-side endpoint of the byte-serial CPU bus.
// Collects 18-slot frames and serves 64-bit word reads/writes.
module mem_bus_responder #(
  parameter int ADDR_BITS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sync,
  input  logic [7:0] addr_in,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       wr_done,
  output logic       err
);

  localparam int WORDS = 1 << ADDR_BITS;

  logic [4:0]           s;
  logic [4:0]           slot;
  logic [2:0]           bsel;
  logic [63:0]          addr_q;
  logic [63:0]          wdata_q;
  logic [63:0]          rd_sr;
  logic [63:0]          mem [WORDS];
  logic [ADDR_BITS-1:0] idx;
  logic                 oor;
  logic                 wr_flag;
  logic                 cap;
  logic                 dec;
  logic                 shift;
  logic [63:0]          rd_word;

  // sync forces the current cycle to be slot 0
  assign slot    = sync ? 5'd0 : s;
  assign bsel    = 3'(slot - 5'd1);
  assign idx     = addr_q[ADDR_BITS+2:3];
  assign oor     = |addr_q[63:ADDR_BITS+3];
  assign wr_flag = addr_in[0];
  assign rd_word = oor ? 64'd0 : mem[idx];

  assign cap   = (slot >= 5'd1) && (slot <= 5'd8);
  assign dec   = (slot == 5'd9);
  assign shift = (slot >= 5'd10) && (slot <= 5'd16);

  always_ff @(posedge clk) begin
    if (rst) begin
      s        <= 5'd0;
      addr_q   <= 64'd0;
      wdata_q  <= 64'd0;
      rd_sr    <= 64'd0;
      data_out <= 8'd0;
      data_oe  <= 1'b0;
      wr_done  <= 1'b0;
      err      <= 1'b0;
      for (int i = 0; i < WORDS; i++)
        mem[i] <= 64'd0;
    end else begin
      s       <= (slot == 5'd17) ? 5'd0 : slot + 5'd1;
      wr_done <= 1'b0;
      err     <= 1'b0;
      unique case (1'b1)
        cap: begin
          addr_q[{bsel, 3'b000} +: 8]  <= addr_in;
          wdata_q[{bsel, 3'b000} +: 8] <= data_in;
        end
        dec: begin
          err <= oor;
          if (wr_flag) begin
            rd_sr <= 64'd0;
            if (!oor) begin
              mem[idx] <= wdata_q;
              wr_done  <= 1'b1;
            end
          end else begin
            // word is frozen here; later writes do not disturb it
            rd_sr    <= rd_word;
            data_out <= rd_word[63:56];
            data_oe  <= 1'b1;
          end
        end
        shift: begin
          rd_sr    <= rd_sr << 8;
          data_out <= rd_sr[55:48];
        end
        default: begin
          rd_sr    <= 64'd0;
          data_out <= 8'd0;
          data_oe  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_bus_responder.md
# mem_bus_responder

Memory-side endpoint of the CPU's byte-serial bus. It sits on the far side of the pins driven by the CPU handler. Each 18-slot frame it:
- collects the 64-bit address and write data, one byte per slot;
- decodes the read/write flag;
- on a write, commits the word to an internal 64-bit-wide register memory;
- on a read, drives the stored word back one byte per slot, MSB first.

It replaces external memory for bring-up and simulation of the CPU handler.

## Interface
Parameters:
- ADDR_BITS, 4, word-index width; memory holds 2^ADDR_BITS 64-bit words

Ports:
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- sync  input  1  frame marker; high means the current cycle is slot 0
- addr_in  input  8  address byte / flag lane (connects to handler uo_out)
- data_in  input  8  write-data lane (connects to handler uio_out)
- data_out  output  8  read-data byte toward handler uio_in
- data_oe  output  1  high while responder drives data_out
- wr_done  output  1  one-cycle pulse: a write was committed
- err  output  1  one-cycle pulse: frame address out of range

## Operation
- Slot counter s, 5 bits, runs 0..17 and wraps 17->0.
  - sync=1 in a cycle: that cycle is slot 0 regardless of s; s=1 next cycle.
- Capture rules, at the rising edge ending each cycle:
  - s=1..8: addr_in -> addr byte s-1; data_in -> wdata byte s-1. Byte 0 is bits [7:0] (LSB first).
  - s=9: addr_in[0] is the frame write flag W (1 = write, 0 = read). addr_in[7:1] are ignored.
- Address decode:
  - Word index = addr[ADDR_BITS+2:3].
  - addr[2:0] are ignored (word-aligned access).
  - Any set bit in addr[63:ADDR_BITS+3] makes the frame out of range.
- End of s=9, in range, W=1:
  - mem[index] <= wdata.
  - wr_done=1 for the next cycle.
  - data_oe stays 0.
- End of s=9, in range, W=0:
  - data_oe <= 1.
  - data_out <= mem[index][63:56].
- End of s=9, out of range:
  - err=1 for the next cycle.
  - A write is dropped.
  - A read still asserts data_oe and returns all-zero bytes.
- End of s=10..16: data_out <= next lower byte of the latched read word. Order is [63:56], [55:48], …, [7:0] across s=10..17.
- End of s=17: data_out <= 0, data_oe <= 0.
- Read word latch:
  - Latched into a 64-bit shift register at the s=9 edge.
  - Later memory state does not affect the bytes in flight.
- s=0 and s=10..17: addr_in/data_in are ignored, except at the s=9 flag edge described above.
- Only one transaction per frame; no pipelining across frames.

## Timing
Reset values (cycle after rst=1 sampled):
- s=0.
- data_out=0, data_oe=0, wr_done=0, err=0.
- All capture registers = 0.
- All memory words = 0.

Alignment with the handler:
- Handler bytes change on the falling edge mid-cycle; responder samples on the rising edge ending that cycle.
- First read byte is valid from the start of the s=10 cycle, so the handler's mid-cycle sample in slot 10 sees byte [63:56].

Latency and event rules:
- Write-to-readback latency: the next frame may read the new value.
- rst mid-frame: the frame is abandoned, no memory write, outputs to reset values, s=0.
- sync and rst together: rst wins.
- sync arriving at s=10..17 of a read frame: drive is aborted the same edge (data_oe=0, data_out=0).
- A write committed at the s=9 edge is never undone by a later sync.
- wr_done and err are never both high.

## Test plan
- Reset: hold rst 2 cycles -> data_out=0, data_oe=0, wr_done=0, err=0; a read of address 0x0 returns eight 0x00 bytes.
- Write/readback:
  - Write frame: addr 0x0000_0000_0000_0018, data 0x0123_4567_89AB_CDEF, W=1 -> wr_done pulse in s=10.
  - Next read frame, same address -> data_oe=1 over s=10..17 with bytes 01,23,45,67,89,AB,CD,EF; data_oe=0 at s=0.
- Aliasing: address 0x1C (low bits ignored) reads the same word as 0x18; address 0x78 (index 15) is independent of index 3.
- Out of range: write to 0x0000_0001_0000_0000 -> err pulse, no wr_done, memory unchanged; read of the same address -> data_oe high with eight 0x00 bytes plus an err pulse.
- Reset mid-frame: assert rst at s=5 of a write to index 2 -> index 2 stays 0; next frame proceeds normally from slot 0.
- Sync realignment: pulse sync when s=7 -> responder treats that cycle as slot 0, and a following full write/read pair at index 1 round-trips 0xFEDC_BA98_7654_3210.
